// File: rtl/lvds_rx_deframer_pkg.sv
// Framing definitions for the 2-bit DDR LVDS I/Q sample link.
// The RX deframer and the TX framer both build on these constants.
package lvds_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } rxState_e;

    localparam int SAMPLE_W = 13;

    localparam logic [1:0]  SYNC_A     = 2'b10;
    localparam logic [1:0]  SYNC_B     = 2'b01;
    localparam logic        MARKER     = 1'b1;
    localparam logic [31:0] ZERO_FRAME = 32'h0000_0000;

    // Fixed bits: [31:30] sync A, [16] marker, [15:14] sync B, [0] zero.
    localparam logic [31:0] HEADER_MASK  = 32'hC001_C001;
    localparam logic [31:0] HEADER_VALUE = {SYNC_A, 13'd0, MARKER, SYNC_B, 13'd0, 1'b0};

    localparam int I_MSB = 29;
    localparam int I_LSB = 17;
    localparam int Q_MSB = 13;
    localparam int Q_LSB = 1;

    function automatic logic [31:0] buildFrame(input logic [SAMPLE_W-1:0] iSample,
                                               input logic [SAMPLE_W-1:0] qSample);
        return {SYNC_A, iSample, MARKER, SYNC_B, qSample, 1'b0};
    endfunction

    function automatic logic [7:0] satInc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/lvds_rx_deframer_frame_check.sv
// Combinational decode of a 32-bit window of the bit stream into
// header/idle flags and the two sample fields.
module lvds_rx_frame_check
    import lvds_pkg::*;
(
    input  logic [31:0]         sr_i,
    output logic                isHeader_o,
    output logic                isIdle_o,
    output logic [SAMPLE_W-1:0] iSample_o,
    output logic [SAMPLE_W-1:0] qSample_o
);

    assign isHeader_o = (sr_i & HEADER_MASK) == HEADER_VALUE;
    assign isIdle_o   = (sr_i == ZERO_FRAME);
    assign iSample_o  = sr_i[I_MSB:I_LSB];
    assign qSample_o  = sr_i[Q_MSB:Q_LSB];

endmodule

// File: rtl/lvds_rx_deframer.sv
// LVDS RX deframer: hunts for the I/Q frame boundary, qualifies lock over
// several frames and pushes extracted samples into the RX FIFO.
module lvds_rx_deframer
    import lvds_pkg::*;
#(
    parameter int LOCK_FRAMES = 4,
    parameter int LOSS_FRAMES = 3
) (
    input  logic        i_ddr_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_ddr_data,
    input  logic        i_rx_enable,
    input  logic        i_fifo_full,
    output logic        o_fifo_push,
    output logic [31:0] o_fifo_data,
    output logic        o_lock,
    output logic [7:0]  o_frame_err_cnt,
    output logic [7:0]  o_overflow_cnt,
    output logic [1:0]  o_state
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
    localparam logic [7:0] LOSS_N = 8'(LOSS_FRAMES);

    rxState_e            state_q;
    logic [31:0]         sr_q;
    logic [31:0]         sr_d;
    logic [3:0]          phase_q;
    logic [7:0]          good_q;
    logic [7:0]          bad_q;
    logic [7:0]          frameErr_q;
    logic [7:0]          overflow_q;
    logic                lock_q;
    logic                push_q;
    logic [31:0]         data_q;
    logic                isHeader;
    logic                isIdle;
    logic                frameSlot;
    logic [SAMPLE_W-1:0] iSample;
    logic [SAMPLE_W-1:0] qSample;

    assign sr_d      = {sr_q[29:0], i_ddr_data};
    assign frameSlot = (phase_q == 4'd15);

    lvds_rx_frame_check u_frameCheck (
        .sr_i       (sr_q),
        .isHeader_o (isHeader),
        .isIdle_o   (isIdle),
        .iSample_o  (iSample),
        .qSample_o  (qSample)
    );

    // The phase counter is re-zeroed on a HUNT match so that count 15 lines
    // up with the cycle in which the shift register holds a whole frame.
    always_ff @(posedge i_ddr_clk) begin
        if (i_rst) begin
            state_q    <= ST_HUNT;
            sr_q       <= '0;
            phase_q    <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            frameErr_q <= '0;
            overflow_q <= '0;
            lock_q     <= 1'b0;
            push_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            sr_q    <= sr_d;
            phase_q <= phase_q + 4'd1;
            push_q  <= 1'b0;
            if (!i_rx_enable) begin
                state_q <= ST_HUNT;
                lock_q  <= 1'b0;
                good_q  <= '0;
                bad_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (isHeader) begin
                            phase_q <= '0;
                            good_q  <= 8'd1;
                            if (LOCK_N <= 8'd1) begin
                                state_q <= ST_LOCKED;
                                lock_q  <= 1'b1;
                            end else begin
                                state_q <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (frameSlot) begin
                            if (isHeader) begin
                                good_q <= satInc(good_q);
                                if (good_q + 8'd1 >= LOCK_N) begin
                                    state_q <= ST_LOCKED;
                                    lock_q  <= 1'b1;
                                    bad_q   <= '0;
                                end
                            end else if (!isIdle) begin
                                state_q <= ST_HUNT;
                                good_q  <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // A bad frame never pushes, so it can never also count as an overflow.
                        if (frameSlot) begin
                            if (isHeader) begin
                                bad_q <= '0;
                                if (i_fifo_full) begin
                                    overflow_q <= satInc(overflow_q);
                                end else begin
                                    push_q <= 1'b1;
                                    data_q <= {3'b000, iSample, 3'b000, qSample};
                                end
                            end else if (!isIdle) begin
                                bad_q      <= satInc(bad_q);
                                frameErr_q <= satInc(frameErr_q);
                                if (bad_q + 8'd1 >= LOSS_N) begin
                                    state_q <= ST_HUNT;
                                    lock_q  <= 1'b0;
                                    good_q  <= '0;
                                    bad_q   <= '0;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_HUNT;
                        lock_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_fifo_push     = push_q;
    assign o_fifo_data     = data_q;
    assign o_lock          = lock_q;
    assign o_frame_err_cnt = frameErr_q;
    assign o_overflow_cnt  = overflow_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Self-checking bench for lvds_rx_deframer: a per-frame vector table for
// acquisition/lock/loss, plus hand sequences for overflow, enable and reset.
module tb_lvds_rx_deframer;

    // Hand-packed frames: FD is I=0x0ABC Q=0x1234, FB is FD with sync A broken,
    // F2 is I=0x1FFF Q=0x0001.
    localparam logic [31:0] IDLE = 32'h0000_0000;
    localparam logic [31:0] FD   = 32'h9579_6468;
    localparam logic [31:0] FB   = 32'h5579_6468;
    localparam logic [31:0] F2   = 32'hBFFF_4002;
    localparam logic [31:0] FD_DATA = 32'h0ABC_1234;
    localparam logic [31:0] F2_DATA = 32'h1FFF_0001;
    localparam int NVEC = 36;

    typedef struct {
        logic [31:0] frame;
        logic [1:0]  expState;
        logic        expLock;
        int          expPushes;
        logic [7:0]  expErr;
    } vec_t;

    logic        clk;
    logic        i_rst;
    logic [1:0]  i_ddr_data;
    logic        i_rx_enable;
    logic        i_fifo_full;
    logic        o_fifo_push;
    logic [31:0] o_fifo_data;
    logic        o_lock;
    logic [7:0]  o_frame_err_cnt;
    logic [7:0]  o_overflow_cnt;
    logic [1:0]  o_state;

    int          errors;
    int          checks;
    int          cyc;
    int          pushCount;
    logic [31:0] lastData;
    int          pushCyc[$];
    vec_t        tbl[NVEC];

    lvds_rx_deframer #(
        .LOCK_FRAMES (4),
        .LOSS_FRAMES (3)
    ) dut (
        .i_ddr_clk       (clk),
        .i_rst           (i_rst),
        .i_ddr_data      (i_ddr_data),
        .i_rx_enable     (i_rx_enable),
        .i_fifo_full     (i_fifo_full),
        .o_fifo_push     (o_fifo_push),
        .o_fifo_data     (o_fifo_data),
        .o_lock          (o_lock),
        .o_frame_err_cnt (o_frame_err_cnt),
        .o_overflow_cnt  (o_overflow_cnt),
        .o_state         (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bit pair per clock; outputs are observed 1 time unit after the edge.
    task automatic applyStimulus(input logic [1:0] pair);
        @(negedge clk);
        i_ddr_data = pair;
        @(posedge clk);
        #1;
        cyc++;
        if (o_fifo_push) begin
            pushCount++;
            lastData = o_fifo_data;
            pushCyc.push_back(cyc);
        end
    endtask

    task automatic sendFrame(input logic [31:0] f);
        for (int p = 15; p >= 0; p--) applyStimulus(f[2*p+1 -: 2]);
    endtask

    task automatic checkRow(input int i);
        checkOutput($sformatf("row%0d_state", i), {30'd0, o_state}, {30'd0, tbl[i].expState});
        checkOutput($sformatf("row%0d_lock", i), {31'd0, o_lock}, {31'd0, tbl[i].expLock});
        checkOutput($sformatf("row%0d_pushes", i), pushCount, tbl[i].expPushes);
        checkOutput($sformatf("row%0d_err", i), {24'd0, o_frame_err_cnt}, {24'd0, tbl[i].expErr});
        checkOutput($sformatf("row%0d_ovf", i), {24'd0, o_overflow_cnt}, 32'd0);
        if (tbl[i].expPushes > 0)
            checkOutput($sformatf("row%0d_data", i), lastData, FD_DATA);
    endtask

    initial begin
        int lastPairCyc;
        int pushBase;

        errors = 0;
        checks = 0;
        cyc = 0;
        pushCount = 0;
        lastData = '0;
        lastPairCyc = 0;
        i_rst = 1'b1;
        i_ddr_data = 2'b00;
        i_rx_enable = 1'b1;
        i_fifo_full = 1'b0;

        // Expected state after each frame has been evaluated at its slot.
        for (int i = 0; i < 10; i++) tbl[i] = '{IDLE, 2'd0, 1'b0, 0, 8'd0};
        tbl[10] = '{FD,   2'd1, 1'b0, 0, 8'd0};
        tbl[11] = '{FD,   2'd1, 1'b0, 0, 8'd0};
        tbl[12] = '{FD,   2'd1, 1'b0, 0, 8'd0};
        tbl[13] = '{FD,   2'd2, 1'b1, 0, 8'd0};
        tbl[14] = '{FD,   2'd2, 1'b1, 1, 8'd0};
        tbl[15] = '{FD,   2'd2, 1'b1, 2, 8'd0};
        tbl[16] = '{IDLE, 2'd2, 1'b1, 2, 8'd0};
        tbl[17] = '{FD,   2'd2, 1'b1, 3, 8'd0};
        tbl[18] = '{IDLE, 2'd2, 1'b1, 3, 8'd0};
        tbl[19] = '{FD,   2'd2, 1'b1, 4, 8'd0};
        tbl[20] = '{IDLE, 2'd2, 1'b1, 4, 8'd0};
        tbl[21] = '{IDLE, 2'd2, 1'b1, 4, 8'd0};
        tbl[22] = '{FD,   2'd2, 1'b1, 5, 8'd0};
        tbl[23] = '{FB,   2'd2, 1'b1, 5, 8'd1};
        tbl[24] = '{FD,   2'd2, 1'b1, 6, 8'd1};
        tbl[25] = '{FB,   2'd2, 1'b1, 6, 8'd2};
        tbl[26] = '{FD,   2'd2, 1'b1, 7, 8'd2};
        tbl[27] = '{FB,   2'd2, 1'b1, 7, 8'd3};
        tbl[28] = '{FB,   2'd2, 1'b1, 7, 8'd4};
        tbl[29] = '{FB,   2'd0, 1'b0, 7, 8'd5};
        tbl[30] = '{IDLE, 2'd0, 1'b0, 7, 8'd5};
        tbl[31] = '{FD,   2'd1, 1'b0, 7, 8'd5};
        tbl[32] = '{FD,   2'd1, 1'b0, 7, 8'd5};
        tbl[33] = '{FD,   2'd1, 1'b0, 7, 8'd5};
        tbl[34] = '{FD,   2'd2, 1'b1, 7, 8'd5};
        tbl[35] = '{FD,   2'd2, 1'b1, 8, 8'd5};

        $display("[TB] reset");
        applyStimulus(2'b00);
        applyStimulus(2'b00);
        checkOutput("reset_state", {30'd0, o_state}, 32'd0);
        checkOutput("reset_lock", {31'd0, o_lock}, 32'd0);
        checkOutput("reset_push", {31'd0, o_fifo_push}, 32'd0);
        checkOutput("reset_data", o_fifo_data, 32'd0);
        checkOutput("reset_err", {24'd0, o_frame_err_cnt}, 32'd0);
        checkOutput("reset_ovf", {24'd0, o_overflow_cnt}, 32'd0);
        i_rst = 1'b0;

        // Arbitrary bit-pair offset before the first frame.
        repeat (5) applyStimulus(2'b00);

        $display("[TB] vector table: acquisition, gaps, errors, loss and re-lock");
        for (int i = 0; i < NVEC; i++) begin
            sendFrame(tbl[i].frame);
            if (i == 14) lastPairCyc = cyc;
            if (i > 0) checkRow(i - 1);
        end
        sendFrame(IDLE);
        checkRow(NVEC - 1);
        checkOutput("first_push_cycle", pushCyc[0], lastPairCyc + 1);
        checkOutput("push_spacing", pushCyc[1] - pushCyc[0], 32'd16);

        $display("[TB] overflow with FIFO full for 300 frames");
        pushBase = pushCount;
        i_fifo_full = 1'b1;
        repeat (100) sendFrame(F2);
        checkOutput("ovf_after_100", {24'd0, o_overflow_cnt}, 32'd99);
        repeat (200) sendFrame(F2);
        sendFrame(IDLE);
        checkOutput("ovf_saturated", {24'd0, o_overflow_cnt}, 32'd255);
        checkOutput("ovf_lock_held", {31'd0, o_lock}, 32'd1);
        checkOutput("ovf_no_pushes", pushCount - pushBase, 32'd0);
        checkOutput("ovf_data_held", o_fifo_data, FD_DATA);
        checkOutput("ovf_err_held", {24'd0, o_frame_err_cnt}, 32'd5);
        i_fifo_full = 1'b0;
        pushBase = pushCount;
        sendFrame(F2);
        sendFrame(F2);
        checkOutput("f2_push_count", pushCount - pushBase, 32'd1);
        checkOutput("f2_push_data", lastData, F2_DATA);
        checkOutput("f2_ovf_held", {24'd0, o_overflow_cnt}, 32'd255);

        $display("[TB] rx_enable dropped for one frame");
        pushBase = pushCount;
        i_rx_enable = 1'b0;
        sendFrame(FD);
        checkOutput("dis_lock", {31'd0, o_lock}, 32'd0);
        checkOutput("dis_state", {30'd0, o_state}, 32'd0);
        checkOutput("dis_no_push", pushCount - pushBase, 32'd0);
        i_rx_enable = 1'b1;
        for (int n = 0; n < 8 && !o_lock; n++) sendFrame(FD);
        checkOutput("reen_lock", {31'd0, o_lock}, 32'd1);
        checkOutput("reen_err_kept", {24'd0, o_frame_err_cnt}, 32'd5);
        checkOutput("reen_ovf_kept", {24'd0, o_overflow_cnt}, 32'd255);

        $display("[TB] reset pulse at a pending push");
        sendFrame(FD);
        pushBase = pushCount;
        i_rst = 1'b1;
        applyStimulus(2'b10);
        i_rst = 1'b0;
        checkOutput("rst_state", {30'd0, o_state}, 32'd0);
        checkOutput("rst_lock", {31'd0, o_lock}, 32'd0);
        checkOutput("rst_push_dropped", pushCount - pushBase, 32'd0);
        checkOutput("rst_data", o_fifo_data, 32'd0);
        checkOutput("rst_err", {24'd0, o_frame_err_cnt}, 32'd0);
        checkOutput("rst_ovf", {24'd0, o_overflow_cnt}, 32'd0);
        sendFrame(IDLE);
        repeat (4) sendFrame(FD);
        checkOutput("relock_not_early", {31'd0, o_lock}, 32'd0);
        checkOutput("relock_verify", {30'd0, o_state}, 32'd1);
        sendFrame(FD);
        checkOutput("relock_lock", {31'd0, o_lock}, 32'd1);
        sendFrame(IDLE);
        checkOutput("relock_push_count", pushCount - pushBase, 32'd1);
        checkOutput("relock_push_data", lastData, FD_DATA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
